// File: rtl/signed_dec_printer_pkg.sv
// Shared types and constants for the signed decimal printer.
// Optional hex output is enabled by defining SIGNED_DEC_PRINTER_HEX_EN.
package printer_pkg;

    // Print-path states; HEXPFX is only reachable when hex output is built in.
    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SIGN,
        DIGIT,
        HEXPFX,
        SEP
    } state_e;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_X     = 8'h78;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    // ceil(width * log10(2)) in integer arithmetic; exact for widths up to 64.
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASC_ZERO + {4'h0, n};
        end
        return ASC_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/signed_dec_printer_if.sv
// Value-input and UART-side handshake bundle for signed_dec_printer.
// hex_mode exists only when SIGNED_DEC_PRINTER_HEX_EN is defined.
interface signed_dec_printer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] val_in;
    logic              val_valid;
    logic              val_ready;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              tx_busy;
    logic              busy;
`ifdef SIGNED_DEC_PRINTER_HEX_EN
    logic              hex_mode;
`endif

    // Producer / UART side.
    modport master (
`ifdef SIGNED_DEC_PRINTER_HEX_EN
        output hex_mode,
`endif
        output val_in,
        output val_valid,
        output tx_busy,
        input  val_ready,
        input  tx_data,
        input  new_tx_data,
        input  busy
    );

    // Printer side.
    modport slave (
`ifdef SIGNED_DEC_PRINTER_HEX_EN
        input  hex_mode,
`endif
        input  val_in,
        input  val_valid,
        input  tx_busy,
        output val_ready,
        output tx_data,
        output new_tx_data,
        output busy
    );

endinterface

// File: rtl/signed_dec_printer_bin2bcd_iter.sv
// Iterative double-dabble converter: one shift-add-3 step per clock.
// The start cycle already performs the first shift, so a conversion takes
// exactly DATA_W clock edges and done rises after the last one.
module bin2bcd_iter #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                running_q;
    logic                done_q;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start (with the first shift folded in), then shift until the count runs out.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            bin_q     <= {bin[DATA_W-2:0], 1'b0};
            bcd_q     <= {{(4*DIGITS-1){1'b0}}, bin[DATA_W-1]};
            cnt_q     <= CNT_W'(DATA_W - 1);
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else if (running_q) begin
            bin_q <= {bin_q[DATA_W-2:0], 1'b0};
            bcd_q <= {bcd_adj[4*DIGITS-2:0], bin_q[DATA_W-1]};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                running_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/signed_dec_printer.sv
// Signed decimal printer: accepts signed values, converts them to ASCII
// decimal (optional '-', no leading zeros, trailing SEP_CHAR) and paces the
// bytes into a UART transmitter over tx_data / new_tx_data / tx_busy.
// Defining SIGNED_DEC_PRINTER_HEX_EN adds a hex_mode input that prints the
// raw value as "0x" plus all hex digits instead.
module signed_dec_printer
    import printer_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter int         DIGITS   = 10,
    parameter logic [7:0] SEP_CHAR = ASC_LF
) (
    input logic                 clk,
    input logic                 rst,
    signed_dec_printer_if.slave bus
);

`ifdef SIGNED_DEC_PRINTER_HEX_EN
    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int MAX_IDX    = (DIGITS > HEX_DIGITS) ? DIGITS : HEX_DIGITS;
`else
    localparam int MAX_IDX    = DIGITS;
`endif
    localparam int IDX_W = $clog2(MAX_IDX);

    typedef logic [IDX_W-1:0] idx_t;

    // Reject configurations the converter cannot represent.
    if (DATA_W < 4 || DATA_W > 64) begin : g_bad_width
        $error("signed_dec_printer: DATA_W must be in 4..64");
    end
    if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
        $error("signed_dec_printer: DIGITS too small for DATA_W");
    end

    state_e              state_q;
    logic                sign_q;
    logic                val_ready_q;
    logic                busy_q;
    logic                new_tx_q;
    logic                guard_q;
    logic [7:0]          tx_data_q;
    idx_t                idx_q;

    logic                accept;
    logic                conv_start;
    logic                conv_done;
    logic                emit_ok;
    logic [DATA_W-1:0]   mag;
    logic [4*DIGITS-1:0] bcd;
    idx_t                lead_idx;
    logic [3:0]          dec_nib;
    logic [7:0]          digit_char;

`ifdef SIGNED_DEC_PRINTER_HEX_EN
    logic                  hex_q;
    logic                  pfx_q;
    logic [4*HEX_DIGITS-1:0] raw_q;
    logic [3:0]            hex_nib;
`endif

    assign accept = (state_q == IDLE) && val_ready_q && bus.val_valid;

`ifdef SIGNED_DEC_PRINTER_HEX_EN
    assign conv_start = accept && !bus.hex_mode;
`else
    assign conv_start = accept;
`endif

    // Magnitude as unsigned DATA_W bits; the most-negative value maps to 2^(DATA_W-1).
    assign mag = bus.val_in[DATA_W-1] ? (~bus.val_in) + DATA_W'(1) : bus.val_in;

    // A strobe cycle and the guard cycle after it never emit, whatever tx_busy says.
    assign emit_ok = !bus.tx_busy && !new_tx_q && !guard_q;

    bin2bcd_iter #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Find the highest nonzero BCD nibble and select the nibble being printed.
    always_comb begin
        lead_idx = '0;
        dec_nib  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                lead_idx = idx_t'(i);
            end
            if (idx_q == idx_t'(i)) begin
                dec_nib = bcd[4*i +: 4];
            end
        end
    end

`ifdef SIGNED_DEC_PRINTER_HEX_EN
    // Select the raw hex nibble being printed.
    always_comb begin
        hex_nib = '0;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            if (idx_q == idx_t'(i)) begin
                hex_nib = raw_q[4*i +: 4];
            end
        end
    end

    assign digit_char = hex_q ? hex_char(hex_nib) : ASC_ZERO + {4'h0, dec_nib};
`else
    assign digit_char = ASC_ZERO + {4'h0, dec_nib};
`endif

    // Print FSM with registered handshake outputs, strobe and guard tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            val_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            new_tx_q    <= 1'b0;
            guard_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            idx_q       <= '0;
`ifdef SIGNED_DEC_PRINTER_HEX_EN
            hex_q       <= 1'b0;
            pfx_q       <= 1'b0;
            raw_q       <= '0;
`endif
        end else begin
            new_tx_q <= 1'b0;
            guard_q  <= new_tx_q;
            case (state_q)
                IDLE: begin
                    val_ready_q <= 1'b1;
                    if (accept) begin
                        val_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        sign_q      <= bus.val_in[DATA_W-1];
`ifdef SIGNED_DEC_PRINTER_HEX_EN
                        hex_q       <= bus.hex_mode;
                        raw_q       <= (4*HEX_DIGITS)'(bus.val_in);
                        pfx_q       <= 1'b0;
                        state_q     <= bus.hex_mode ? HEXPFX : CONVERT;
`else
                        state_q     <= CONVERT;
`endif
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        idx_q   <= lead_idx;
                        state_q <= sign_q ? SIGN : DIGIT;
                    end
                end
                SIGN: begin
                    if (emit_ok) begin
                        tx_data_q <= ASC_MINUS;
                        new_tx_q  <= 1'b1;
                        state_q   <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (emit_ok) begin
                        tx_data_q <= digit_char;
                        new_tx_q  <= 1'b1;
                        if (idx_q == '0) begin
                            state_q <= SEP;
                        end else begin
                            idx_q <= idx_q - idx_t'(1);
                        end
                    end
                end
`ifdef SIGNED_DEC_PRINTER_HEX_EN
                HEXPFX: begin
                    if (emit_ok) begin
                        tx_data_q <= pfx_q ? ASC_X : ASC_ZERO;
                        new_tx_q  <= 1'b1;
                        if (pfx_q) begin
                            idx_q   <= idx_t'(HEX_DIGITS - 1);
                            state_q <= DIGIT;
                        end else begin
                            pfx_q <= 1'b1;
                        end
                    end
                end
`endif
                SEP: begin
                    if (emit_ok) begin
                        tx_data_q   <= SEP_CHAR;
                        new_tx_q    <= 1'b1;
                        val_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    val_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.val_ready   = val_ready_q;
    assign bus.busy        = busy_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_q;

endmodule
